// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and sign helpers for muldiv_unit
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Helpers work on a fixed wide type; callers zero-extend in and truncate out,
    // which keeps two's-complement results correct for any XLEN up to 64.
    localparam int MAX_W = 128;
    typedef logic [MAX_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_e;

    function automatic wide_t negate(input wide_t v);
        return ~v + wide_t'(1);
    endfunction

    function automatic wide_t abs_val(input wide_t v, input logic neg);
        return neg ? negate(v) : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - one shift-add multiply or restoring-divide iteration
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     rem,
    input  logic [XLEN-1:0]     x,
    input  logic [XLEN-1:0]     y,
    output logic [2*XLEN-1:0]   acc_n,
    output logic [XLEN-1:0]     rem_n,
    output logic [XLEN-1:0]     x_n
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] divisor;
    logic          ge;

    // Multiply: x is the multiplier consumed LSB first, y the multiplicand.
    // Divide: x is the dividend shifting out MSB first while quotient bits shift in.
    always_comb begin
        sum       = {1'b0, acc[2*XLEN-1:XLEN]} + (x[0] ? {1'b0, y} : '0);
        rem_shift = {rem, x[XLEN-1]};
        divisor   = {1'b0, y};
        ge        = rem_shift >= divisor;
        if (is_div) begin
            acc_n = acc;
            rem_n = XLEN'(ge ? rem_shift - divisor : rem_shift);
            x_n   = {x[XLEN-2:0], ge};
        end else begin
            acc_n = (2*XLEN)'({sum, acc[XLEN-1:0]} >> 1);
            rem_n = rem;
            x_n   = x >> 1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with start/busy handshake
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                a_neg_q, a_neg_d;
    logic                b_neg_q, b_neg_d;
    logic [XLEN-1:0]     opa_q, opa_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;

    logic                accept;
    logic                a_signed, b_signed;
    logic                a_is_neg, b_is_neg;
    logic                b_zero, ovf, special;
    logic [XLEN-1:0]     spec_res;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rmd;
    logic [2*XLEN-1:0]   core_acc;
    logic [XLEN-1:0]     core_rem, core_x;

    muldiv_core #(.XLEN(XLEN)) u_core (
        .is_div (op_q[2]),
        .acc    (acc_q),
        .rem    (rem_q),
        .x      (opa_q),
        .y      (opb_q),
        .acc_n  (core_acc),
        .rem_n  (core_rem),
        .x_n    (core_x)
    );

    assign start_ready  = (state_q == IDLE) && !flush;
    assign accept       = start_valid && start_ready;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

    // Accept decode, iteration sequencing, sign fix-up and abort handling.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_is_neg = a_signed && a[XLEN-1];
        b_is_neg = b_signed && b[XLEN-1];

        // Divide corner cases resolve immediately without iterating.
        b_zero   = (b == '0);
        ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special  = op[2] && (b_zero || ovf);
        if (b_zero)
            spec_res = op[1] ? a : '1;
        else
            spec_res = op[1] ? '0 : a;

        prod = (a_neg_q ^ b_neg_q) ? (2*XLEN)'(negate(wide_t'(acc_q))) : acc_q;
        quo  = (a_neg_q ^ b_neg_q) ? XLEN'(negate(wide_t'(opa_q))) : opa_q;
        rmd  = a_neg_q ? XLEN'(negate(wide_t'(rem_q))) : rem_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op;
                    a_neg_d = a_is_neg;
                    b_neg_d = b_is_neg;
                    opa_d   = XLEN'(abs_val(wide_t'(a), a_is_neg));
                    opb_d   = XLEN'(abs_val(wide_t'(b), b_is_neg));
                    acc_d   = '0;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(XLEN);
                    if (special) begin
                        state_d  = DONE;
                        result_d = spec_res;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = core_acc;
                rem_d = core_rem;
                opa_d = core_x;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0)
                    state_d = SIGN;
            end
            SIGN: begin
                case (op_q)
                    OP_MUL:                       result_d = prod[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:              result_d = quo;
                    OP_REM, OP_REMU:              result_d = rmd;
                    default:                      result_d = result_q;
                endcase
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end

        result_valid_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    // State and datapath registers; reset wins over flush and start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            op_q           <= '0;
            a_neg_q        <= 1'b0;
            b_neg_q        <= 1'b0;
            opa_q          <= '0;
            opb_q          <= '0;
            acc_q          <= '0;
            rem_q          <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            a_neg_q        <= a_neg_d;
            b_neg_q        <= b_neg_d;
            opa_q          <= opa_d;
            opb_q          <= opb_d;
            acc_q          <= acc_d;
            rem_q          <= rem_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int WIN  = 40;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            start_valid;
    logic            start_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    // RISC-V M-extension semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint     sx, sy, ux, uy;
        int         si, sj;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        si = $signed(x);
        sj = $signed(y);
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return si / sj;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return si % sj;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 2;
    endfunction

    function automatic logic [WIN:0] busy_exp(input int l);
        logic [WIN:0] m = '0;
        for (int c = 1; c <= WIN; c++) m[c] = (c <= l);
        return m;
    endfunction

    function automatic logic [WIN:0] ready_exp(input int l);
        logic [WIN:0] m = '0;
        for (int c = 1; c <= WIN; c++) m[c] = (c > l);
        return m;
    endfunction

    // Issues one operation and observes cycles 1..WIN after the accept edge.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output int pulses,
                          output logic [WIN:0] busy_m, output logic [WIN:0] ready_m, output logic acc_ok);
        @(negedge clk);
        op = f; a = x; b = y; start_valid = 1'b1;
        acc_ok = start_ready;
        @(negedge clk);
        start_valid = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0; pulses = 0; res = 'x; busy_m = '0; ready_m = '0;
        for (int c = 1; c <= WIN; c++) begin
            if (c > 1) @(negedge clk);
            busy_m[c]  = busy;
            ready_m[c] = start_ready;
            if (result_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = c;
                    res = result;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; start_valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else n_pass++;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", result_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (start_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", start_ready); else n_pass++;
    endtask

    task automatic test_directed;
        logic [2:0]  t_op  [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] t_a   [14] = '{32'd7, '1, '1, '1, '1, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                                    32'hFFFF_FFFE, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [14] = '{32'hFFFF_FFFD, '1, '1, '1, '1, 32'd2, 32'd2, 32'd2, 32'd2,
                                    32'd3, 32'd0, 32'd0, '1, '1};
        logic [31:0] t_exp [14] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h1,
                                    32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'h5555_5554,
                                    32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int t_lat [14] = '{34, 34, 34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
        logic [31:0]  res;
        int           lat, pulses;
        logic [WIN:0] bm, rm;
        logic         acc_ok;
        for (int i = 0; i < 14; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat, pulses, bm, rm, acc_ok);
            n_checks++; if (acc_ok !== 1'b1) $display("FAIL dir_accept[%0d] got %b want 1", i, acc_ok); else n_pass++;
            n_checks++; if (res !== t_exp[i]) $display("FAIL dir_result[%0d] got %h want %h", i, res, t_exp[i]); else n_pass++;
            n_checks++; if (lat != t_lat[i]) $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, t_lat[i]); else n_pass++;
            n_checks++; if (pulses != 1) $display("FAIL dir_pulses[%0d] got %0d want 1", i, pulses); else n_pass++;
            n_checks++; if (bm !== busy_exp(t_lat[i])) $display("FAIL dir_busy[%0d] got %h want %h", i, bm, busy_exp(t_lat[i])); else n_pass++;
            n_checks++; if (rm !== ready_exp(t_lat[i])) $display("FAIL dir_ready[%0d] got %h want %h", i, rm, ready_exp(t_lat[i])); else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [2:0]   f;
        logic [31:0]  x, y, res, want;
        int           lat, pulses, wl, sel;
        logic [WIN:0] bm, rm;
        logic         acc_ok;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) y = 32'h0;
            else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            else if (sel == 2) y = 32'($urandom_range(1, 15));
            else if (sel == 3) y = -32'($urandom_range(1, 15));
            want = ref_model(f, x, y);
            wl   = exp_lat(f, x, y);
            run_op(f, x, y, res, lat, pulses, bm, rm, acc_ok);
            n_checks++; if (acc_ok !== 1'b1) $display("FAIL rnd_accept[%0d] got %b want 1", i, acc_ok); else n_pass++;
            n_checks++; if (res !== want) $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h got %h want %h", i, f, x, y, res, want); else n_pass++;
            n_checks++; if (lat != wl) $display("FAIL rnd_latency[%0d] got %0d want %0d", i, lat, wl); else n_pass++;
            n_checks++; if (pulses != 1) $display("FAIL rnd_pulses[%0d] got %0d want 1", i, pulses); else n_pass++;
            n_checks++; if (bm !== busy_exp(wl)) $display("FAIL rnd_busy[%0d] got %h want %h", i, bm, busy_exp(wl)); else n_pass++;
            n_checks++; if (rm !== ready_exp(wl)) $display("FAIL rnd_ready[%0d] got %h want %h", i, rm, ready_exp(wl)); else n_pass++;
        end
    endtask

    // Abort a DIV in cycle 10 via flush (use_rst=0) or reset (use_rst=1).
    task automatic test_abort(input bit use_rst);
        logic [31:0]  res, kept;
        int           lat, pulses, rv_seen;
        logic [WIN:0] bm, rm;
        logic         acc_ok;
        run_op(3'd0, 32'd5, 32'd6, res, lat, pulses, bm, rm, acc_ok);
        kept = use_rst ? 32'h0 : 32'd30;
        rv_seen = 0;
        @(negedge clk);
        op = 3'd4; a = 32'd100; b = 32'd7; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (result_valid) rv_seen++;
            if (c == 10) begin
                if (use_rst) rst = 1'b1; else flush = 1'b1;
                start_valid = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
            end
        end
        @(posedge clk);
        #1 rst = 1'b0; flush = 1'b0; start_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (start_ready !== 1'b1) $display("FAIL abort%0d_ready got %b want 1", use_rst, start_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort%0d_busy got %b want 0", use_rst, busy); else n_pass++;
        n_checks++; if (result !== kept) $display("FAIL abort%0d_result got %h want %h", use_rst, result, kept); else n_pass++;
        for (int c = 11; c <= 45; c++) begin
            if (result_valid) rv_seen++;
            @(negedge clk);
        end
        n_checks++; if (rv_seen != 0) $display("FAIL abort%0d_no_valid got %0d pulses want 0", use_rst, rv_seen); else n_pass++;
        n_checks++; if (result !== kept) $display("FAIL abort%0d_result_held got %h want %h", use_rst, result, kept); else n_pass++;
        run_op(3'd0, 32'd3, 32'd4, res, lat, pulses, bm, rm, acc_ok);
        n_checks++; if (res !== 32'd12) $display("FAIL abort%0d_next_mul got %h want %h", use_rst, res, 32'd12); else n_pass++;
        n_checks++; if (lat != XLEN + 2) $display("FAIL abort%0d_next_lat got %0d want %0d", use_rst, lat, XLEN + 2); else n_pass++;
    endtask

    // start_valid held high with changing operands while busy.
    task automatic test_back_to_back;
        logic [31:0] want1, want2;
        logic [31:0] res [2];
        int          when [2];
        int          pulses;
        logic        ready35;
        want1 = ref_model(3'd0, 32'h0001_2345, 32'h0000_6789);
        want2 = ref_model(3'd5, 32'd1000, 32'd7);
        pulses = 0; ready35 = 1'b0;
        res[0] = 'x; res[1] = 'x; when[0] = 0; when[1] = 0;
        @(negedge clk);
        op = 3'd0; a = 32'h0001_2345; b = 32'h0000_6789; start_valid = 1'b1;
        @(negedge clk);
        op = 3'd5; a = 32'd1000; b = 32'd7;
        for (int c = 1; c <= 80; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 35) ready35 = start_ready;
            if (c == 36) start_valid = 1'b0;
            if (result_valid) begin
                if (pulses < 2) begin
                    res[pulses]  = result;
                    when[pulses] = c;
                end
                pulses++;
            end
        end
        n_checks++; if (pulses != 2) $display("FAIL b2b_pulses got %0d want 2", pulses); else n_pass++;
        n_checks++; if (res[0] !== want1) $display("FAIL b2b_first_result got %h want %h", res[0], want1); else n_pass++;
        n_checks++; if (when[0] != XLEN + 2) $display("FAIL b2b_first_cycle got %0d want %0d", when[0], XLEN + 2); else n_pass++;
        n_checks++; if (ready35 !== 1'b1) $display("FAIL b2b_ready_after_done got %b want 1", ready35); else n_pass++;
        n_checks++; if (res[1] !== want2) $display("FAIL b2b_second_result got %h want %h", res[1], want2); else n_pass++;
        n_checks++; if (when[1] != 2 * XLEN + 5) $display("FAIL b2b_second_cycle got %0d want %0d", when[1], 2 * XLEN + 5); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
